alarm_scan_sequencer: RTL
=========================

// Module: alarm_scan_sequencer
// PURPOSE
//   Time-multiplexes one alarm_monitor instance across NCH sensor channel pairs.
//   Round-robin scan: drive channel's sensors + mode, wait settle, capture alarm_leds/pwr_reg.
//   Keeps sticky per-channel alarm flags with SW ack; raises irq. Sits between sensor bank and monitor.
// PARAMETERS
//   NCH     4  number of sensor channel pairs scanned (2..16)
//   SETTLE  2  cycles held after setup before capture (>=1; matches monitor's 2-clk response)
//   CH_W    2  channel index width, = clog2(NCH)
// PORTS
//   clk             in   1        clock, rising edge
//   rst_n           in   1        reset, asynchronous, active-high
//   en              in   1        scan enable (level)
//   cfg_mode        in   2        monitor mode for next scan
//   ch_sens_a       in   4*NCH    sensor_a per channel, ch k at [4k+3:4k]
//   ch_sens_b       in   4*NCH    sensor_b per channel, same packing
//   ack             in   NCH      W1C per-channel flag clear (pulse)
//   mon_sensor_a    out  4        to monitor sensor_a
//   mon_sensor_b    out  4        to monitor sensor_b
//   mon_mode        out  2        to monitor mode
//   mon_alarm_leds  in   3        from monitor alarm_leds
//   mon_pwr_reg     in   4        from monitor pwr_reg
//   alarm_flags     out  NCH      sticky alarm per channel
//   last_ch         out  CH_W     channel of most recent capture
//   last_leds       out  3        alarm_leds captured for last_ch
//   last_pwr        out  4        pwr_reg captured for last_ch
//   scan_done       out  1        1-cycle pulse after last channel captured
//   busy            out  1        1 when state != IDLE
//   irq             out  1        registered |alarm_flags
// BEHAVIOUR
//   Reset (rst_n=1): state=IDLE, ch=0, all outputs 0.
//   FSM: IDLE -> SETUP -> SETTLE -> CAPTURE -> (SETUP | IDLE).
//   IDLE: mon_* = 0; en=1 -> SETUP, ch=0, latch cfg_mode into mon_mode.
//   SETUP (1 cyc): register mon_sensor_a/b <= ch_sens_a/b[ch]; held stable until CAPTURE exits.
//   SETTLE (SETTLE cyc): down-counter from SETTLE-1; at 0 -> CAPTURE.
//   CAPTURE (1 cyc): last_ch<=ch, last_leds<=mon_alarm_leds, last_pwr<=mon_pwr_reg;
//     mon_alarm_leds!=0 -> set alarm_flags[ch]. Then:
//     ch==NCH-1: scan_done=1 next cycle, ch<=0, relatch cfg_mode; en ? SETUP : IDLE.
//     else ch<=ch+1; en ? SETUP : IDLE (aborted scan, ch<=0, no scan_done).
//   Per-channel period = SETTLE+2 cycles; full scan = NCH*(SETTLE+2) (16 at defaults).
//   cfg_mode changes only take effect at scan start; mid-scan changes ignored.
//   en drop mid-channel: current channel completes through CAPTURE, then IDLE.
//   ack[k] clears flag k next edge; same-cycle set and ack on k: set wins.
//   irq follows alarm_flags by one cycle; scan_done and irq independent.
//   Async reset mid-scan: immediate return to reset values, flags lost.
// CONFIGURATION
//   ALARM_DEBOUNCE_EN defined: flag[k] set only when channel k nonzero in 2 consecutive
//     captures of k (per-channel 1-bit history; zero capture or ack clears history).
//   Undefined: flag set on first nonzero capture; no history regs.
// TESTING  (bench models monitor: alarm_leds = table[mode][sensors], 2-clk latency)
//   Reset then en=1, all sensors 0 -> mon_sensor_a/b = ch0..3 in order, scan_done every 16 clks, flags=0.
//   ch2 a=4'hF,b=4'h3 -> model leds=3'b101 -> flags=4'b0100, last_ch=2, last_leds=101, irq next cycle.
//   ack=4'b0100 same cycle as ch2 recapture nonzero -> flag stays 1; ack on idle cycle -> flag 0, irq 0.
//   cfg_mode 00->11 mid-scan -> mon_mode stays 00 until ch0 SETUP of next scan, then 11.
//   en=0 during ch1 SETTLE -> ch1 captured, busy=0 two cycles later, no scan_done, restart begins ch0.
//   ALARM_DEBOUNCE_EN: ch3 nonzero one scan then zero -> flag 0; two consecutive -> flag[3]=1.

Source files
------------

// File: rtl/alarm_scan_sequencer.sv
// alarm_scan_sequencer: round-robin scan of NCH sensor channel pairs through one shared alarm_monitor
// Build option: define ALARM_DEBOUNCE_EN to flag a channel only after two consecutive nonzero captures.
module alarm_scan_sequencer #(
  parameter int NCH    = 4,
  parameter int SETTLE = 2,
  parameter int CH_W   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        cfg_mode,
  input  logic [4*NCH-1:0]  ch_sens_a,
  input  logic [4*NCH-1:0]  ch_sens_b,
  input  logic [NCH-1:0]    ack,
  output logic [3:0]        mon_sensor_a,
  output logic [3:0]        mon_sensor_b,
  output logic [1:0]        mon_mode,
  input  logic [2:0]        mon_alarm_leds,
  input  logic [3:0]        mon_pwr_reg,
  output logic [NCH-1:0]    alarm_flags,
  output logic [CH_W-1:0]   last_ch,
  output logic [2:0]        last_leds,
  output logic [3:0]        last_pwr,
  output logic              scan_done,
  output logic              busy,
  output logic              irq
);
  localparam int CNT_W = $clog2(SETTLE + 1);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SETTLE, S_CAPTURE} state_t;
  state_t          r_state;
  logic [CH_W-1:0] r_ch;
  logic [CNT_W-1:0] r_cnt;
  logic [NCH-1:0]  w_sel;
  logic [NCH-1:0]  w_set;
  logic            w_cap;
  logic            w_hit;
  logic            w_last;
  logic            w_arm;
  assign w_cap  = r_state == S_CAPTURE;
  assign w_hit  = |mon_alarm_leds;
  assign w_last = r_ch == CH_W'(NCH - 1);
  assign w_sel  = NCH'(1) << r_ch;
  assign w_set  = (w_cap && w_hit && w_arm) ? w_sel : '0;
  assign busy   = r_state != S_IDLE;
`ifdef ALARM_DEBOUNCE_EN
  logic [NCH-1:0] r_hist;
  assign w_arm = |(r_hist & w_sel);
  // per-channel memory of whether the previous capture was nonzero; ack forgets it
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) r_hist <= '0;
    else r_hist <= w_cap ? ((r_hist & ~ack & ~w_sel) | (w_hit ? w_sel : '0)) : (r_hist & ~ack);
`else
  assign w_arm = 1'b1;
`endif
  // sticky flags: capture sets, ack clears, a same-cycle set beats the ack; irq trails by one cycle
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      alarm_flags <= '0;
      irq         <= 1'b0;
    end else begin
      alarm_flags <= (alarm_flags & ~ack) | w_set;
      irq         <= |alarm_flags;
    end
  // scan FSM: present one channel, let the monitor settle, capture its response, move on
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      r_state      <= S_IDLE;
      r_ch         <= '0;
      r_cnt        <= '0;
      mon_sensor_a <= '0;
      mon_sensor_b <= '0;
      mon_mode     <= '0;
      last_ch      <= '0;
      last_leds    <= '0;
      last_pwr     <= '0;
      scan_done    <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      case (r_state)
        S_IDLE: if (en) begin
          r_state  <= S_SETUP;
          r_ch     <= '0;
          mon_mode <= cfg_mode;
        end
        S_SETUP: begin
          mon_sensor_a <= ch_sens_a[{r_ch, 2'b00} +: 4];
          mon_sensor_b <= ch_sens_b[{r_ch, 2'b00} +: 4];
          r_cnt        <= CNT_W'(SETTLE - 1);
          r_state      <= S_SETTLE;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          last_ch   <= r_ch;
          last_leds <= mon_alarm_leds;
          last_pwr  <= mon_pwr_reg;
          scan_done <= w_last;
          r_ch      <= (w_last || !en) ? '0 : CH_W'(r_ch + 1'b1);
          r_state   <= en ? S_SETUP : S_IDLE;
          if (w_last) mon_mode <= cfg_mode;
          if (!en) begin
            mon_sensor_a <= '0;
            mon_sensor_b <= '0;
            mon_mode     <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule
